// File: rtl/inst_fetch.sv
// Instruction fetch: issues one request at a time on the instruction bus and lands data in a one-entry IF/ID register.
// Latency: request to valid_o is address-accept cycle plus data latency plus one register cycle (2 instructions per 4 cycles at best).
// Backpressure: stall_i holds the output register and blocks new requests; flush_i discards in-flight data. Optional IF_ADEL_EN adds misaligned-PC traps.
module inst_fetch #(
  parameter logic [31:0] NOP_INST = 32'h00000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic [31:0] pc_plus4_o,
  output logic        pc_advance_o,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [31:0] inst_rdata_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        adel_o
);

  typedef enum logic [1:0] {
    REQ       = 2'd0,
    WAIT_DATA = 2'd1,
    DISCARD   = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] req_pc;
  logic        out_free;
  logic        misaligned;
  logic        take_data;
  logic        adel_load;

  // A request may only go out when the output register will have room for its answer.
  assign out_free = !valid_o || !stall_i;

`ifdef IF_ADEL_EN
  assign misaligned = (pc_i[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign pc_plus4_o   = pc_i + 32'd4;
  assign inst_req_o   = !rst_i && (state == REQ) && out_free && !flush_i && !misaligned;
  assign inst_addr_o  = pc_i;
  assign pc_advance_o = inst_req_o && inst_addr_ok_i;

  assign take_data = (state == WAIT_DATA) && inst_data_ok_i && !flush_i;
  assign adel_load = (state == REQ) && misaligned && out_free && !flush_i;

  // Request tracking: remembers the PC of the outstanding request and whether its data is still wanted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= REQ;
      req_pc <= 32'h0;
    end else begin
      case (state)
        REQ: begin
          if (pc_advance_o) begin
            state  <= WAIT_DATA;
            req_pc <= pc_i;
          end
        end
        WAIT_DATA: begin
          if (inst_data_ok_i) begin
            state <= REQ;
          end else if (flush_i) begin
            state <= DISCARD;
          end
        end
        DISCARD: begin
          if (inst_data_ok_i) begin
            state <= REQ;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

  // IF/ID register: flush wins, then a load, then consumption; stall holds everything.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      pc_o    <= 32'hbfc00000;
      inst_o  <= NOP_INST;
    end else if (flush_i) begin
      valid_o <= 1'b0;
      inst_o  <= NOP_INST;
    end else if (take_data) begin
      valid_o <= 1'b1;
      pc_o    <= req_pc;
      inst_o  <= inst_rdata_i;
    end else if (adel_load) begin
      valid_o <= 1'b1;
      pc_o    <= pc_i;
      inst_o  <= NOP_INST;
    end else if (valid_o && !stall_i) begin
      valid_o <= 1'b0;
      inst_o  <= NOP_INST;
    end
  end

`ifdef IF_ADEL_EN
  logic adel_q;

  // Address-error flag travels with the entry and clears whenever the entry leaves or is replaced.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      adel_q <= 1'b0;
    end else if (flush_i) begin
      adel_q <= 1'b0;
    end else if (take_data) begin
      adel_q <= 1'b0;
    end else if (adel_load) begin
      adel_q <= 1'b1;
    end else if (valid_o && !stall_i) begin
      adel_q <= 1'b0;
    end
  end

  assign adel_o = adel_q;
`else
  assign adel_o = 1'b0;
`endif

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch stage that sits directly downstream of the PC register.
- Takes the current PC, issues one request at a time on a SRAM-like instruction bus, and tells the PC register when to advance.
- Presents fetched instruction plus its PC to the IF/ID boundary through a one-entry output register.
- Handles downstream stall and pipeline flush, discarding stale in-flight responses.

Parameters:
- NOP_INST, 32'h00000000, value driven on inst_o when no valid instruction is held (reset, flush, exception slot).

Ports:
- clk_i  input  1  clock; all state updates on posedge
- rst_i  input  1  asynchronous active-high reset
- pc_i  input  32  current PC from PC register
- stall_i  input  1  downstream stall; output register must hold
- flush_i  input  1  pipeline flush; PC register is being redirected this cycle
- pc_plus4_o  output  32  pc_i + 4, combinational, wraps mod 2^32
- pc_advance_o  output  1  PC register loads pc_plus4_o this cycle
- inst_req_o  output  1  instruction bus request
- inst_addr_o  output  32  request address
- inst_addr_ok_i  input  1  address accepted this cycle (valid only with inst_req_o)
- inst_data_ok_i  input  1  read data returned this cycle
- inst_rdata_i  input  32  read data
- valid_o  output  1  output register holds an instruction
- pc_o  output  32  PC of held instruction
- inst_o  output  32  held instruction
- adel_o  output  1  held entry is an instruction-fetch address error (IF_ADEL_EN only; else tied 0)

Behaviour:
- Async reset:
  - state = REQ; valid_o = 0; pc_o = 32'hbfc00000; inst_o = NOP_INST; adel_o = 0.
  - Combinational outputs follow state, so inst_req_o = 0 during reset.
- States:
  - REQ: ready to issue.
  - WAIT_DATA: one request outstanding, response wanted.
  - DISCARD: one request outstanding, response to be dropped.
- out_free = !valid_o | !stall_i. The output register is empty or being consumed this cycle.
- REQ:
  - inst_req_o = out_free & !flush_i; inst_addr_o = pc_i.
  - pc_advance_o = inst_req_o & inst_addr_ok_i.
  - Request with addr_ok → WAIT_DATA; latch req_pc = pc_i.
  - Request without addr_ok → stay REQ. Address follows pc_i; pc_i is stable unless a flush occurs.
- WAIT_DATA:
  - inst_req_o = 0.
  - On inst_data_ok_i & !flush_i: load valid_o = 1, pc_o = req_pc, inst_o = inst_rdata_i; → REQ.
  - On inst_data_ok_i & flush_i: data dropped; → REQ.
  - On flush_i without data_ok → DISCARD.
- DISCARD:
  - inst_req_o = 0; the first inst_data_ok_i is dropped; → REQ.
  - A further flush_i stays in DISCARD.
- Output register:
  - Consumed when valid_o & !stall_i; valid_o clears unless reloaded in the same cycle.
  - flush_i clears valid_o (inst_o ← NOP_INST) with priority over a load.
  - stall_i holds valid_o/pc_o/inst_o unchanged.
- Exactly one outstanding request. A new request issues only when out_free, so a returning response always finds the output register free.
- Back-to-back operation: data_ok in cycle N → REQ in N+1 → re-issue in N+1. Peak rate is one instruction per 2 cycles for a bus with 1-cycle data latency.
- pc_advance_o is never asserted with flush_i.
- Reset mid-request: the instruction bus is reset on the same rst_i, so no stale response arrives after reset.

Optional Feature:
- Macro: IF_ADEL_EN.
- Defined:
  - In REQ, if pc_i[1:0] != 0, no bus request is made and pc_advance_o = 0.
  - When out_free & !flush_i, load valid_o = 1, pc_o = pc_i, inst_o = NOP_INST, adel_o = 1.
  - Stay in REQ until flush_i redirects.
  - adel_o clears with valid_o.
- Undefined: no alignment check; adel_o tied 0; misaligned PCs are fetched with the address as given.

Test Plan:
- Reset release, bus addr_ok same cycle, data_ok next cycle with 32'h24080001 → inst_req_o with addr bfc00000, pc_advance_o = 1 for one cycle; next cycle valid_o = 1, pc_o = bfc00000, inst_o = 24080001.
- stall_i held 3 cycles while valid_o = 1 → outputs unchanged; inst_req_o = 0 throughout; request to bfc00004 issues in the cycle stall_i drops.
- flush_i in WAIT_DATA, data_ok 2 cycles later with 32'hdeadbeef → data never appears on inst_o; next request uses the redirected pc_i (e.g. bfc00380).
- flush_i in the same cycle as inst_data_ok_i → valid_o = 0 next cycle; immediate REQ with new PC; pc_advance_o never overlaps flush_i.
- inst_addr_ok_i withheld 4 cycles → inst_req_o stays 1 with a constant address; pc_advance_o = 0 until accept.
- IF_ADEL_EN with pc_i = bfc00002 → no inst_req_o; valid_o = 1, adel_o = 1, pc_o = bfc00002, inst_o = 0. Without the macro → request issued to bfc00002.
